// File: rtl/y_mon_pkg.sv
// y_mon_pkg: state encoding and default parameters for the Y event counter.
package y_mon_pkg;
  typedef enum logic [1:0] {
    LOW      = 2'd0,
    RISE_CHK = 2'd1,
    HIGH     = 2'd2,
    FALL_CHK = 2'd3
  } state_t;
  localparam int FILT_CYCLES_DEF = 4;
  localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/y_event_counter_if.sv
// y_event_counter_if: Y input, clear and event-count outputs of the event counter.
interface y_event_counter_if #(parameter int CNT_W = y_mon_pkg::CNT_W_DEF);
  logic Y;
  logic clr;
  logic y_filt;
  logic rise_pulse;
  logic [CNT_W-1:0] count;
  logic overflow;
  modport master (output Y, clr, input y_filt, rise_pulse, count, overflow);
  modport slave (input Y, clr, output y_filt, rise_pulse, count, overflow);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous level.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/y_event_counter.sv
// y_event_counter: debounces Y, strobes on accepted rising edges and counts them with saturation.
module y_event_counter
  import y_mon_pkg::*;
#(
  parameter int FILT_CYCLES = FILT_CYCLES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk,
  input logic rst_n,
  y_event_counter_if.slave bus
);
  localparam logic [3:0] F_LAST = 4'(FILT_CYCLES - 1);
  logic y_s;
  state_t state, state_nx;
  logic [3:0] fcnt, fcnt_nx;
  logic done, rise;
  sync_2ff u_sync (.clk(clk), .rst_n(rst_n), .d(bus.Y), .q(y_s));
  assign done = fcnt == F_LAST;
  assign rise = state == RISE_CHK && y_s && done;
  always_comb begin
    state_nx = state;
    fcnt_nx = '0;
    case (state)
      LOW:      if (y_s) begin state_nx = RISE_CHK; fcnt_nx = 4'd1; end
      RISE_CHK: if (!y_s) state_nx = LOW; else if (done) state_nx = HIGH; else fcnt_nx = fcnt + 4'd1;
      HIGH:     if (!y_s) begin state_nx = FALL_CHK; fcnt_nx = 4'd1; end
      FALL_CHK: if (y_s) state_nx = HIGH; else if (done) state_nx = LOW; else fcnt_nx = fcnt + 4'd1;
    endcase
  end
  // clr only touches the counter/flag; the filter and strobe keep running
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= LOW;
      fcnt <= '0;
      bus.y_filt <= 1'b0;
      bus.rise_pulse <= 1'b0;
      bus.count <= '0;
      bus.overflow <= 1'b0;
    end else begin
      state <= state_nx;
      fcnt <= fcnt_nx;
      bus.y_filt <= state_nx == HIGH || state_nx == FALL_CHK;
      bus.rise_pulse <= rise;
      if (bus.clr) begin
        bus.count <= '0;
        bus.overflow <= 1'b0;
      end else if (rise) begin
        if (bus.count == '1) bus.overflow <= 1'b1;
        else bus.count <= bus.count + 1'b1;
      end
    end
endmodule

// File: tb/tb_y_event_counter.sv
// tb_y_event_counter: directed stimulus with queued expectations checked by a negedge monitor.
module tb_y_event_counter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  typedef struct {
    string name;
    logic yf;
    logic rp;
    logic [7:0] cnt;
    logic ov;
  } snap_t;
  typedef struct {
    string name;
    logic [7:0] cnt;
    logic ov;
  } pulse_t;
  snap_t snap_q[$];
  pulse_t pulse_q[$];
  y_event_counter_if #(.CNT_W(8)) bus ();
  y_event_counter #(.FILT_CYCLES(4), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    while (snap_q.size() > 0) begin
      snap_t s;
      s = snap_q.pop_front();
      n_checks++;
      if ({bus.y_filt, bus.rise_pulse, bus.count, bus.overflow} !== {s.yf, s.rp, s.cnt, s.ov}) begin
        n_fail++;
        $display("FAIL %s: got y_filt=%b rise=%b count=%0d ovf=%b, want y_filt=%b rise=%b count=%0d ovf=%b",
                 s.name, bus.y_filt, bus.rise_pulse, bus.count, bus.overflow, s.yf, s.rp, s.cnt, s.ov);
      end
    end
    if (bus.rise_pulse === 1'b1) begin
      n_checks++;
      if (pulse_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: got rise_pulse=1 count=%0d at %0t, want no pulse", bus.count, $time);
      end else begin
        pulse_t p;
        p = pulse_q.pop_front();
        if ({bus.count, bus.overflow} !== {p.cnt, p.ov}) begin
          n_fail++;
          $display("FAIL %s: got count=%0d ovf=%b on pulse, want count=%0d ovf=%b",
                   p.name, bus.count, bus.overflow, p.cnt, p.ov);
        end
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string name, input logic yf, input logic rp, input logic [7:0] cnt, input logic ov);
    snap_q.push_back('{name, yf, rp, cnt, ov});
  endtask
  task automatic exp_pulse(input string name, input logic [7:0] cnt, input logic ov);
    pulse_q.push_back('{name, cnt, ov});
  endtask
  task automatic clean_pulse();
    bus.Y = 1'b1;
    tick(8);
    bus.Y = 1'b0;
    tick(8);
  endtask
  initial begin
    bus.Y = 1'b0;
    bus.clr = 1'b0;
    #1;
    chk("reset_state", 0, 0, 8'd0, 0);
    tick(2);
    rst_n = 1'b1;
    bus.Y = 1'b1;
    tick(5);
    chk("before_edge6", 0, 0, 8'd0, 0);
    exp_pulse("first_rise", 8'd1, 0);
    tick(1);
    chk("edge6_rise", 1, 1, 8'd1, 0);
    tick(1);
    chk("pulse_one_cycle", 1, 0, 8'd1, 0);
    tick(3);
    chk("held_high_10", 1, 0, 8'd1, 0);
    bus.Y = 1'b0;
    tick(2);
    bus.Y = 1'b1;
    tick(6);
    chk("glitch_low_in_high", 1, 0, 8'd1, 0);
    bus.Y = 1'b0;
    tick(8);
    chk("settled_low", 0, 0, 8'd1, 0);
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
    chk("clr_count", 0, 0, 8'd0, 0);
    bus.Y = 1'b1;
    tick(3);
    bus.Y = 1'b0;
    tick(8);
    chk("short_high_rejected", 0, 0, 8'd0, 0);
    for (int i = 0; i < 256; i++) begin
      exp_pulse("sat_pulse", i < 255 ? 8'(i + 1) : 8'd255, i == 255);
      clean_pulse();
    end
    chk("saturated", 0, 0, 8'd255, 1);
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
    chk("clr_overflow", 0, 0, 8'd0, 0);
    for (int i = 0; i < 5; i++) begin
      exp_pulse("count_to_5", 8'(i + 1), 0);
      clean_pulse();
    end
    chk("count_is_5", 0, 0, 8'd5, 0);
    bus.Y = 1'b1;
    tick(5);
    chk("pre_clr_collision", 0, 0, 8'd5, 0);
    bus.clr = 1'b1;
    exp_pulse("clr_wins_pulse", 8'd0, 0);
    tick(1);
    bus.clr = 1'b0;
    chk("clr_wins", 1, 1, 8'd0, 0);
    tick(1);
    chk("clr_wins_after", 1, 0, 8'd0, 0);
    bus.Y = 1'b0;
    tick(8);
    exp_pulse("pre_reset_rise", 8'd1, 0);
    clean_pulse();
    chk("pre_reset_count", 0, 0, 8'd1, 0);
    bus.Y = 1'b1;
    tick(4);
    rst_n = 1'b0;
    #1;
    chk("async_reset_midfilter", 0, 0, 8'd0, 0);
    tick(1);
    rst_n = 1'b1;
    exp_pulse("post_reset_rise", 8'd1, 0);
    tick(5);
    chk("post_reset_edge5", 0, 0, 8'd0, 0);
    tick(1);
    chk("post_reset_edge6", 1, 1, 8'd1, 0);
    tick(3);
    n_checks++;
    if (pulse_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_pulses: got %0d expected pulses outstanding, want 0", pulse_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/y_event_counter.md
Y_EVENT_COUNTER -- requirements
Module: y_event_counter

Interface
REQ-001 Parameter FILT_CYCLES, default 4: number of consecutive identical synchronized samples needed to accept a level change on Y; legal range 2..16.
REQ-002 Parameter CNT_W, default 8: width of the event counter; legal range 4..16.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Y  input  1  asynchronous output of the upstream combinational function block.
REQ-006 clr  input  1  synchronous clear of count and overflow.
REQ-007 y_filt  output  1  filtered, registered level of Y.
REQ-008 rise_pulse  output  1  one-cycle strobe on each accepted rising event.
REQ-009 count  output  CNT_W  number of accepted rising events, saturating.
REQ-010 overflow  output  1  sticky flag: a rising event arrived while count was at maximum.

Function
REQ-011 Y SHALL pass through a two-flop synchronizer; its second-stage output is y_s.
REQ-012 The FSM SHALL have four states: LOW, RISE_CHK, HIGH, FALL_CHK.
REQ-013 Filter counter fcnt SHALL be 4 bits wide and count from 0 to FILT_CYCLES-1.
REQ-014 In LOW: y_s=1 goes to RISE_CHK with fcnt=1; y_s=0 stays in LOW.
REQ-015 In RISE_CHK: y_s=0 returns to LOW with fcnt=0; y_s=1 with fcnt=FILT_CYCLES-1 goes to HIGH; otherwise y_s=1 increments fcnt.
REQ-016 HIGH and FALL_CHK SHALL mirror LOW and RISE_CHK with y_s inverted; FALL_CHK completion goes to LOW.
REQ-017 y_filt SHALL be registered, 1 in HIGH and FALL_CHK, 0 in LOW and RISE_CHK.
REQ-018 rise_pulse SHALL be registered and high for exactly the one cycle after the RISE_CHK->HIGH edge; no pulse on falling events.
REQ-019 Latency: after Y is held high from before edge 1, the RISE_CHK->HIGH transition SHALL occur on edge FILT_CYCLES+2.
REQ-020 count SHALL increment on the same edge as the RISE_CHK->HIGH transition.
REQ-021 At 2^CNT_W-1, count SHALL hold, and an accepted rising event SHALL set overflow.
REQ-022 overflow SHALL remain set until clr or reset.
REQ-023 clr=1 SHALL force count=0 and overflow=0 on the next edge; clr SHALL NOT affect the FSM, fcnt, y_filt or rise_pulse.
REQ-024 If clr and an accepted rising event occur on the same edge, clr SHALL win: count=0, overflow=0, and rise_pulse is still asserted.

Reset
REQ-025 rst_n=0 SHALL immediately force: synchronizer flops=0, state=LOW, fcnt=0, y_filt=0, rise_pulse=0, count=0, overflow=0.
REQ-026 Reset asserted mid-filter SHALL discard partial fcnt progress; after release, a rise requires FILT_CYCLES fresh high samples.
REQ-027 If Y is already high at reset release, that level SHALL be counted as one rising event after the normal latency.

Structure
REQ-028 Shared package y_mon_pkg SHALL hold the state encoding (LOW=0, RISE_CHK=1, HIGH=2, FALL_CHK=3) and the default values of FILT_CYCLES and CNT_W.
REQ-029 The synchronizer SHALL be a separate sub-module, sync_2ff (ports clk, rst_n, d, q), instantiated once.
REQ-030 The implementation SHALL contain no latches and no combinational path from Y to any output.

Verification (FILT_CYCLES=4, CNT_W=8)
REQ-031 Reset, then Y=1 held 10 cycles -> rise_pulse high only in the cycle after edge 6; count=1, y_filt=1.
REQ-032 Y=1 for 3 cycles, then Y=0 -> no rise_pulse, count=0, y_filt=0.
REQ-033 256 clean pulses (8 high / 8 low cycles each) -> count=255 and overflow=1 after the 256th; overflow=0 after clr.
REQ-034 clr asserted on the same edge that produces rise_pulse (count=5 before) -> count=0, rise_pulse still high for one cycle.
REQ-035 In HIGH, Y=0 for 2 cycles then Y=1 -> y_filt stays 1, no rise_pulse, count unchanged.
REQ-036 rst_n pulsed low while in RISE_CHK with fcnt=2 -> all outputs 0 immediately; with Y held high, count=1 exactly 6 edges after release.
